alu_result_queue: RTL and testbench
===================================

ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of the ALU result word.
REQ-002 The block SHALL have parameter DEPTH, default 4, the queue entry count; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter TAG_W, default 5, the width of the destination tag.
REQ-004 The block SHALL have port clk  input  1  as its single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n  input  1  as its synchronous, active-low reset.
REQ-006 The block SHALL have port in_valid  input  1  meaning the ALU result beat is present.
REQ-007 The block SHALL have port in_ready  output  1  meaning the queue can accept a beat.
REQ-008 The block SHALL have port in_result  input  DATA_WIDTH  carrying the signed ALU result.
REQ-009 The block SHALL have ports in_zero  input  1  and in_neg  input  1  carrying the ALU zero and negative flags.
REQ-010 The block SHALL have port in_tag  input  TAG_W  carrying the destination register tag.
REQ-011 The block SHALL have port flush  input  1  giving a synchronous queue clear.
REQ-012 The block SHALL have port out_valid  output  1  meaning the head entry is presented.
REQ-013 The block SHALL have port out_ready  input  1  meaning the consumer takes the head entry.
REQ-014 The block SHALL have ports out_result  output  DATA_WIDTH, out_zero  output  1, out_neg  output  1, and out_tag  output  TAG_W, together forming the head entry.
REQ-015 The block SHALL have port count  output  $clog2(DEPTH)+1  giving the number of occupied entries.
REQ-016 The block SHALL have port overflow_err  output  1  as a sticky flag set when a beat is offered while the queue is full.

Function
REQ-017 Push SHALL occur on a clock edge where in_valid && in_ready && !flush.
REQ-018 Pop SHALL occur on a clock edge where out_valid && out_ready && !flush.
REQ-019 in_ready SHALL be (count < DEPTH), registered-state-derived only, with no combinational path from out_ready.
REQ-020 out_valid SHALL be (count != 0).
REQ-021 The head entry SHALL be presented first-word-fall-through: a beat pushed at edge N is visible on the out_* ports after edge N when the queue was empty (1-cycle latency).
REQ-022 When out_valid is 0, out_result, out_zero, out_neg, and out_tag SHALL be driven to 0.
REQ-023 Entries SHALL be stored and returned unmodified, in strict FIFO order, with flags carried rather than recomputed.
REQ-024 Write and read pointers SHALL wrap modulo DEPTH.
REQ-025 count SHALL increment on push-only, decrement on pop-only, and be unchanged on simultaneous push and pop.
REQ-026 Simultaneous push and pop while full SHALL be impossible because in_ready is 0; the pop proceeds and the offered beat is not stored.
REQ-027 Simultaneous push and pop while empty SHALL be impossible because out_valid is 0; the push proceeds.
REQ-028 out_* SHALL hold stable while out_valid && !out_ready.
REQ-029 overflow_err SHALL be set on any edge with in_valid && !in_ready && !flush, SHALL remain set until reset, and SHALL NOT be cleared by flush.
REQ-030 Flush SHALL zero both pointers and count on that edge, override any push or pop in the same cycle, and leave storage contents don't-care.

Reset
REQ-031 On an edge with rst_n == 0, pointers, count, and overflow_err SHALL go to 0, giving out_valid=0, out_*=0, and in_ready=1 after that edge.
REQ-032 Reset SHALL take priority over flush, push, and pop; entries in flight at reset SHALL be discarded.
REQ-033 Storage array contents SHALL NOT require reset.

Verification
REQ-034 The bench SHALL cover: reset, then push result=0xFFFF_FFF6, neg=1, zero=0, tag=3 with out_ready=0 -> next cycle out_valid=1, out_result=0xFFFF_FFF6, out_neg=1, out_tag=3, count=1.
REQ-035 The bench SHALL cover: push 4 beats with tags 1..4 and out_ready=0 -> count=4, in_ready=0; then offer a 5th beat -> overflow_err=1, count stays 4, and draining returns tags 1,2,3,4 in order.
REQ-036 The bench SHALL cover: with count=2, push and pop in the same cycle -> count stays 2, the head advances by one, and no data is lost.
REQ-037 The bench SHALL cover: run 10 push/pop pairs through DEPTH=4 so the pointers wrap twice -> results are returned in order and identical to those pushed, including result 0 with zero=1.
REQ-038 The bench SHALL cover: with count=3, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, out_*=0, and the offered beat is not stored.
REQ-039 The bench SHALL cover: with count=2 and overflow_err=1, drive rst_n=0 for one edge -> count=0, overflow_err=0, in_ready=1; a subsequent push then appears at the head after 1 cycle.

Source files
------------

// File: rtl/alu_result_queue.sv
// ALU result queue: first-word-fall-through FIFO that carries a signed result,
// its zero/negative flags and a destination tag. It has a synchronous flush
// and a sticky overflow flag.
module alu_result_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TAG_W      = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_result,
    input  logic                       in_zero,
    input  logic                       in_neg,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_result,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 2 + TAG_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;
    logic [EW-1:0] head;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Next-state for pointers, occupancy and the sticky overflow flag
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (in_valid && !in_ready && !flush) begin
            ovf_d = 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage write; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= {in_result, in_zero, in_neg, in_tag};
        end
    end

    // Head entry presentation, forced to zero while the queue is empty
    always_comb begin
        head = out_valid ? mem_q[rd_ptr_q] : '0;
        {out_result, out_zero, out_neg, out_tag} = head;
    end

    assign count        = count_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed self-checking bench for alu_result_queue.
module tb_alu_result_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_zero;
    logic        in_neg;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_neg;
    logic [4:0]  out_tag;
    logic [2:0]  count;
    logic        overflow_err;

    int n_cmp = 0;
    int n_err = 0;

    alu_result_queue #(
        .DATA_WIDTH(32),
        .DEPTH(4),
        .TAG_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_result(in_result),
        .in_zero(in_zero),
        .in_neg(in_neg),
        .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_zero(out_zero),
        .out_neg(out_neg),
        .out_tag(out_tag),
        .count(count),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a push beat and clock it in.
    task automatic push_beat(input logic [31:0] r, input logic z, input logic n, input logic [4:0] t);
        in_valid  = 1'b1;
        in_result = r;
        in_zero   = z;
        in_neg    = n;
        in_tag    = t;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow_err); end
        n_cmp++; if (out_result !== 32'd0 || out_tag !== 5'd0) begin n_err++; $display("FAIL reset_out_zeroed got %h/%0d want 0/0", out_result, out_tag); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_push();
        out_ready = 1'b0;
        push_beat(32'hFFFF_FFF6, 1'b0, 1'b1, 5'd3);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_cmp++; if (out_result !== 32'hFFFF_FFF6) begin n_err++; $display("FAIL single_result got %h want fffffff6", out_result); end
        n_cmp++; if (out_neg !== 1'b1 || out_zero !== 1'b0) begin n_err++; $display("FAIL single_flags got neg=%b zero=%b want 1/0", out_neg, out_zero); end
        n_cmp++; if (out_tag !== 5'd3) begin n_err++; $display("FAIL single_tag got %0d want 3", out_tag); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || out_result !== 32'd0) begin n_err++; $display("FAIL single_pop got cnt=%0d v=%b r=%h want 0/0/0", count, out_valid, out_result); end
    endtask

    task automatic test_full_overflow();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_beat(32'd100 + 32'(i), 1'b0, 1'b0, 5'(i));
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL full_ovf_early got %b want 0", overflow_err); end
        push_beat(32'd105, 1'b0, 1'b0, 5'd5);
        n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow_err); end
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", count); end
        step();
        n_cmp++; if (out_tag !== 5'd1 || out_result !== 32'd101) begin n_err++; $display("FAIL hold_head got %0d/%0d want 1/101", out_tag, out_result); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (out_tag !== 5'(i) || out_result !== 32'd100 + 32'(i) || out_valid !== 1'b1) begin
                n_err++; $display("FAIL drain_%0d got tag=%0d res=%0d v=%b want tag=%0d res=%0d v=1", i, out_tag, out_result, out_valid, i, 100 + i);
            end
            step();
        end
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got cnt=%0d v=%b want 0/0", count, out_valid); end
        n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow_err); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        push_beat(32'hA, 1'b0, 1'b0, 5'd10);
        push_beat(32'hB, 1'b0, 1'b0, 5'd11);
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_pre_count got %0d want 2", count); end
        out_ready = 1'b1;
        push_beat(32'hC, 1'b0, 1'b1, 5'd12);
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count got %0d want 2", count); end
        n_cmp++; if (out_tag !== 5'd11 || out_result !== 32'hB) begin n_err++; $display("FAIL b2b_head got %0d/%h want 11/b", out_tag, out_result); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_tag !== 5'd12 || out_result !== 32'hC || out_neg !== 1'b1) begin n_err++; $display("FAIL b2b_last got %0d/%h/%b want 12/c/1", out_tag, out_result, out_neg); end
        step();
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_empty got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        logic [31:0] r;
        for (int i = 0; i < 10; i++) begin
            r = (i == 5) ? 32'd0 : 32'h1000_0000 + 32'(i);
            out_ready = 1'b0;
            push_beat(r, (i == 5), i[0], 5'(i + 16));
            n_cmp++;
            if (out_valid !== 1'b1 || out_result !== r || out_zero !== (i == 5) || out_neg !== i[0] || out_tag !== 5'(i + 16)) begin
                n_err++; $display("FAIL wrap_%0d got v=%b r=%h z=%b n=%b t=%0d want v=1 r=%h z=%b n=%b t=%0d",
                    i, out_valid, out_result, out_zero, out_neg, out_tag, r, (i == 5), i[0], i + 16);
            end
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL wrap_empty got %0d want 0", count); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_beat(32'h55 + 32'(i), 1'b0, 1'b0, 5'(i + 1));
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre got %0d want 3", count); end
        flush     = 1'b1;
        out_ready = 1'b1;
        push_beat(32'h77, 1'b0, 1'b1, 5'd7);
        flush     = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
        n_cmp++; if (out_result !== 32'd0 || out_tag !== 5'd0 || out_neg !== 1'b0) begin n_err++; $display("FAIL flush_out got %h/%0d/%b want 0/0/0", out_result, out_tag, out_neg); end
        n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL flush_ovf got %b want 1", overflow_err); end
        push_beat(32'h88, 1'b0, 1'b0, 5'd8);
        n_cmp++; if (count !== 3'd1 || out_tag !== 5'd8) begin n_err++; $display("FAIL flush_after got cnt=%0d tag=%0d want 1/8", count, out_tag); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        push_beat(32'h1, 1'b0, 1'b0, 5'd1);
        push_beat(32'h2, 1'b0, 1'b0, 5'd2);
        n_cmp++; if (count !== 3'd2 || overflow_err !== 1'b1) begin n_err++; $display("FAIL rst_pre got cnt=%0d ovf=%b want 2/1", count, overflow_err); end
        rst_n = 1'b0;
        push_beat(32'h3, 1'b0, 1'b0, 5'd3);
        rst_n = 1'b1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", overflow_err); end
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL rst_hs got rdy=%b v=%b want 1/0", in_ready, out_valid); end
        push_beat(32'hDEAD_BEEF, 1'b0, 1'b1, 5'd9);
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 5'd9 || out_result !== 32'hDEAD_BEEF || count !== 3'd1) begin
            n_err++; $display("FAIL rst_push got v=%b t=%0d r=%h c=%0d want 1/9/deadbeef/1", out_valid, out_tag, out_result, count);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_zero   = 1'b0;
        in_neg    = 1'b0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_single_push();
        test_full_overflow();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
